// File: rtl/seq_divider24_pkg.sv
// Shared constants, FSM state type and helpers for the sequential 24-bit divider.
package seq_divider24_pkg;

  localparam int unsigned DIV_WIDTH   = 24;
  localparam int unsigned DIV_LATENCY = 25;
  localparam int unsigned DIV_CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Magnitude of an operand; 0x800000 in signed mode maps to 0x800000 unsigned.
  function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] v,
                                                   input logic                 is_signed);
    return (is_signed && v[DIV_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div24_nr_step.sv
// One radix-2 non-restoring division step: shift in the next dividend bit,
// then add or subtract the divisor magnitude depending on the current sign.
module div24_nr_step
  import seq_divider24_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;

  // The partial remainder stays within [-dmag, dmag), so the dropped MSB is
  // redundant and modulo-2^(WIDTH+1) arithmetic gives the exact result.
  always_comb begin
    shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
    if (rem_in[WIDTH]) begin
      rem_out = shifted + {1'b0, dmag};
    end else begin
      rem_out = shifted - {1'b0, dmag};
    end
    quo_out = {quo_in[WIDTH-2:0], ~rem_out[WIDTH]};
  end

endmodule

// File: rtl/seq_divider24.sv
// Sequential 24-bit signed/unsigned divider, radix-2 non-restoring, valid/ready on both sides.
// Optional SEQ_DIV24_EARLY_EXIT_EN: skip iterations when divisor is 0 or |dividend| < |divisor|.
module seq_divider24
  import seq_divider24_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic             signedFlag,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero,
  output logic             overflow
);

`ifdef SEQ_DIV24_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(DIV_LATENCY - 2);
  localparam logic [WIDTH-1:0]     MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [WIDTH:0]       prem;
  logic [WIDTH-1:0]     qreg;
  logic [WIDTH-1:0]     dmag;
  logic [WIDTH-1:0]     dividend_raw;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div0;
  logic                 ovf;

  logic [WIDTH:0]       prem_nxt;
  logic [WIDTH-1:0]     qreg_nxt;
  logic [WIDTH-1:0]     amag_in;
  logic [WIDTH-1:0]     bmag_in;
  logic                 early;
  logic [WIDTH:0]       prem_fix;
  logic [WIDTH-1:0]     rmag;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;

  div24_nr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (prem),
    .quo_in  (qreg),
    .dmag    (dmag),
    .rem_out (prem_nxt),
    .quo_out (qreg_nxt)
  );

  always_comb begin
    amag_in  = div_abs(dividend, signedFlag);
    bmag_in  = div_abs(divisor, signedFlag);
    early    = EARLY_EXIT && ((divisor == '0) || (amag_in < bmag_in));
    prem_fix = prem[WIDTH] ? (prem + {1'b0, dmag}) : prem;
    rmag     = prem_fix[WIDTH-1:0];
    q_fix    = div0 ? '1 : (neg_q ? -qreg : qreg);
    r_fix    = div0 ? dividend_raw : (neg_r ? -rmag : rmag);
  end

  // Early exit preloads the remainder with |dividend| and a zero quotient,
  // so FIX produces the same result as a full run without special casing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      prem         <= '0;
      qreg         <= '0;
      dmag         <= '0;
      dividend_raw <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div0         <= 1'b0;
      ovf          <= 1'b0;
      inReady      <= 1'b1;
      outValid     <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      divByZero    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            dmag         <= bmag_in;
            dividend_raw <= dividend;
            neg_q        <= signedFlag & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r        <= signedFlag & dividend[WIDTH-1];
            div0         <= (divisor == '0);
            ovf          <= signedFlag && (dividend == MOST_NEG) && (divisor == '1);
            cnt          <= CNT_LOAD;
            inReady      <= 1'b0;
            if (early) begin
              prem  <= {1'b0, amag_in};
              qreg  <= '0;
              state <= FIX;
            end else begin
              prem  <= '0;
              qreg  <= amag_in;
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem <= prem_nxt;
          qreg <= qreg_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          divByZero <= div0;
          overflow  <= ovf;
          outValid  <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (outReady) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider24.sv
// Self-checking bench for seq_divider24: vector table, back-pressure and reset-abort
// sequences, and a random regression against a reference divide model.
`timescale 1ns/1ps
module tb_seq_divider24;
  import seq_divider24_pkg::*;

  localparam int W = 24;
`ifdef SEQ_DIV24_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  localparam int LAT_SHORT = EE ? 1 : 25;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic         signedFlag = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         outValid;
  logic         outReady = 1'b1;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         divByZero;
  logic         overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    string        nm;
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[14];

  seq_divider24 #(.WIDTH(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inValid    (inValid),
    .inReady    (inReady),
    .signedFlag (signedFlag),
    .dividend   (dividend),
    .divisor    (divisor),
    .outValid   (outValid),
    .outReady   (outReady),
    .quotient   (quotient),
    .remainder  (remainder),
    .divByZero  (divByZero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int mag(input logic s, input logic [W-1:0] v);
    int x;
    if (s) x = $signed(v);
    else   x = int'({8'b0, v});
    return (x < 0) ? -x : x;
  endfunction

  function automatic vec_t model(input string nm, input logic s, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    vec_t v;
    int sa, sbv;
    v.nm = nm; v.s = s; v.a = a; v.b = b; v.dz = 1'b0; v.ov = 1'b0;
    if (b == '0) begin
      v.q = '1; v.r = a; v.dz = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sbv = $signed(b);
      if (sa == -8388608 && sbv == -1) begin
        v.q = 24'h800000; v.r = '0; v.ov = 1'b1;
      end else begin
        v.q = W'(sa / sbv);
        v.r = W'(sa % sbv);
      end
    end else begin
      v.q = a / b;
      v.r = a % b;
    end
    v.lat = (EE && (b == '0 || mag(s, a) < mag(s, b))) ? 1 : DIV_LATENCY;
    return v;
  endfunction

  function automatic vec_t mk(input string nm, input logic s, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] q,
                              input logic [W-1:0] r, input logic dz, input logic ov,
                              input int lat);
    vec_t v;
    v.nm = nm; v.s = s; v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz; v.ov = ov; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the output handshake.
  task automatic run_op(input vec_t v, input int hold);
    vec_t e;
    int   c0;
    int   n;
    logic ok;
    n = 0;
    while (!inReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({v.nm, "/in_ready"}, 32'(inReady), 32'd1);
    sb.push_back(v);
    signedFlag = v.s; dividend = v.a; divisor = v.b; inValid = 1'b1;
    outReady = (hold == 0);
    @(negedge clk);
    c0 = cyc;
    inValid = 1'b0;
    dividend = 24'($urandom);
    divisor = 24'($urandom);
    signedFlag = 1'($urandom);
    n = 0;
    while (!outValid && n < 60) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk({e.nm, "/out_valid"}, 32'(outValid), 32'd1);
    chk({e.nm, "/latency"}, 32'(cyc - c0), 32'(e.lat));
    chk({e.nm, "/quotient"}, 32'(quotient), 32'(e.q));
    chk({e.nm, "/remainder"}, 32'(remainder), 32'(e.r));
    chk({e.nm, "/div_by_zero"}, 32'(divByZero), 32'(e.dz));
    chk({e.nm, "/overflow"}, 32'(overflow), 32'(e.ov));
    if (hold > 0) begin
      ok = 1'b1;
      inValid = 1'b1; signedFlag = 1'b0; dividend = 24'd100; divisor = 24'd3;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!outValid || inReady || quotient !== e.q || remainder !== e.r ||
            divByZero !== e.dz || overflow !== e.ov) ok = 1'b0;
      end
      chk({e.nm, "/hold_stable"}, 32'(ok), 32'd1);
      inValid = 1'b0;
      outReady = 1'b1;
    end
    @(negedge clk);
    chk({e.nm, "/ready_after"}, 32'(inReady), 32'd1);
    chk({e.nm, "/valid_cleared"}, 32'(outValid), 32'd0);
    outReady = 1'b1;
  endtask

  initial begin
    vec_t v;
    logic ok;
    logic s;
    logic [W-1:0] a, b;

    tbl[0]  = mk("u_1000_7",      1'b0, 24'd1000,    24'd7,       24'd142,     24'd6,       1'b0, 1'b0, 25);
    tbl[1]  = mk("s_m7_2",        1'b1, 24'hFFFFF9,  24'd2,       24'hFFFFFD,  24'hFFFFFF,  1'b0, 1'b0, 25);
    tbl[2]  = mk("s_7_m2",        1'b1, 24'd7,       24'hFFFFFE,  24'hFFFFFD,  24'd1,       1'b0, 1'b0, 25);
    tbl[3]  = mk("u_max_1",       1'b0, 24'hFFFFFF,  24'd1,       24'hFFFFFF,  24'd0,       1'b0, 1'b0, 25);
    tbl[4]  = mk("s_ovf",         1'b1, 24'h800000,  24'hFFFFFF,  24'h800000,  24'd0,       1'b0, 1'b1, 25);
    tbl[5]  = mk("s_5_0",         1'b1, 24'd5,       24'd0,       24'hFFFFFF,  24'd5,       1'b1, 1'b0, LAT_SHORT);
    tbl[6]  = mk("u_3_10",        1'b0, 24'd3,       24'd10,      24'd0,       24'd3,       1'b0, 1'b0, LAT_SHORT);
    tbl[7]  = mk("u_0_5",         1'b0, 24'd0,       24'd5,       24'd0,       24'd0,       1'b0, 1'b0, LAT_SHORT);
    tbl[8]  = mk("u_max_max",     1'b0, 24'hFFFFFF,  24'hFFFFFF,  24'd1,       24'd0,       1'b0, 1'b0, 25);
    tbl[9]  = mk("s_minneg_1",    1'b1, 24'h800000,  24'd1,       24'h800000,  24'd0,       1'b0, 1'b0, 25);
    tbl[10] = mk("u_800000_max",  1'b0, 24'h800000,  24'hFFFFFF,  24'd0,       24'h800000,  1'b0, 1'b0, LAT_SHORT);
    tbl[11] = mk("s_m100_7",      1'b1, 24'hFFFF9C,  24'd7,       24'hFFFFF2,  24'hFFFFFE,  1'b0, 1'b0, 25);
    tbl[12] = mk("s_3_m10",       1'b1, 24'd3,       24'hFFFFF6,  24'd0,       24'd3,       1'b0, 1'b0, LAT_SHORT);
    tbl[13] = mk("u_0_0",         1'b0, 24'd0,       24'd0,       24'hFFFFFF,  24'd0,       1'b1, 1'b0, LAT_SHORT);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(inReady), 32'd1);
    chk("rst_out_valid", 32'(outValid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_flags", 32'({divByZero, overflow}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(outValid), 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i], 0);
    end

    // Back-pressure: result must hold for 10 cycles while a new request is ignored.
    run_op(mk("bp_200_3", 1'b0, 24'd200, 24'd3, 24'd66, 24'd2, 1'b0, 1'b0, 25), 10);
    run_op(mk("after_bp", 1'b0, 24'd50, 24'd4, 24'd12, 24'd2, 1'b0, 1'b0, 25), 0);

    // Reset abort during CALC, with non-zero previous outputs present.
    run_op(mk("s_5_0_pre", 1'b1, 24'd5, 24'd0, 24'hFFFFFF, 24'd5, 1'b1, 1'b0, LAT_SHORT), 0);
    signedFlag = 1'b0; dividend = 24'hABCDEF; divisor = 24'h000013; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_mid_calc_busy", 32'(inReady), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(outValid), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_flags", 32'({divByZero, overflow}), 32'd0);
    chk("abort_in_ready", 32'(inReady), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (outValid || !inReady) ok = 1'b0;
    end
    chk("abort_no_stale", 32'(ok), 32'd1);
    run_op(mk("u_100_9", 1'b0, 24'd100, 24'd9, 24'd11, 24'd1, 1'b0, 1'b0, 25), 0);

    // Random regression against the reference model.
    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom);
      a = 24'($urandom);
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = 24'($urandom_range(1, 15));
        2:       b = '1;
        3:       b = a ^ 24'($urandom_range(0, 255));
        4:       b = 24'($urandom) >> $urandom_range(4, 20);
        default: b = 24'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) a = a >> $urandom_range(8, 23);
      v = model($sformatf("rand%0d", i), s, a, b);
      run_op(v, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
